aes_encrypt_iter: RTL
=====================

# aes_encrypt_iter

Iterative AES-128 encryption core, one round per clock, wrapping the existing `AES_SubBytes` stage. It feeds `AES_SubBytes` and consumes its output each cycle. It accepts a plaintext/key pair over a valid/ready handshake, runs on-the-fly key expansion, and presents the ciphertext on a held valid/ready output. It is the top of the cipher datapath; `AES_SubBytes` and the ShiftRows/MixColumns logic sit inside its round loop.

## Interface
- `ROUNDS`, 10: number of rounds. Only 10 is FIPS-197 compliant; smaller values are for reduced-round debug only. Legal range 1..10.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  plaintext/key pair offered.
- `in_ready`  out  1  core idle and able to accept.
- `plaintext`  in  128  input block; byte 0 at [127:120], column-major per FIPS-197.
- `key`  in  128  cipher key, same byte order.
- `out_valid`  out  1  ciphertext valid.
- `out_ready`  in  1  consumer accepts ciphertext.
- `ciphertext`  out  128  result, driven directly from the state register.
- `busy`  out  1  high while in ROUND state.

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: state ← plaintext ^ key; rkey ← key; rnd ← 1; go to ROUND.
- ROUND, each cycle:
  - rkey ← KeyStep(rkey, RCON[rnd]).
  - state ← MixColumns(ShiftRows(SubBytes(state))) ^ KeyStep result.
  - When rnd==ROUNDS, MixColumns is bypassed and the FSM goes to DONE. Otherwise rnd ← rnd+1.
- DONE:
  - `out_valid`=1; `ciphertext` is held stable.
  - On `out_valid && out_ready`: go to IDLE.
- KeyStep:
  - temp = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - w0' = w0^temp; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- RCON[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- MixColumns uses GF(2^8) with xtime reduction polynomial 0x11B.
- `in_valid` is ignored outside IDLE; `out_ready` is ignored outside DONE.
- rnd is a 4-bit counter.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `ciphertext`=0. Internal state, rkey and rnd reset to 0; FSM resets to IDLE.
- Latency: if the input is accepted at edge E0, rounds complete at E1..E(ROUNDS), and `out_valid` rises after E(ROUNDS). That is 10 cycles for AES-128.
- DONE→IDLE takes one cycle, so the next accept is possible at the edge after the output handshake. Minimum throughput is one block per ROUNDS+2 cycles.
- An output handshake and a new `in_valid` in the same cycle do not overlap: `in_ready` is 0 in DONE.
- Reset asserted mid-round aborts the block immediately. No partial output is produced, and the block is not resumed.
- No combinational path from `in_valid`/`out_ready` to any output.

## Configuration
- `AES_ENC_ZEROIZE_EN` defined: on the DONE→IDLE transition, state and rkey are cleared to 0. `ciphertext` reads 0 while in IDLE.
- `AES_ENC_ZEROIZE_EN` undefined: registers retain their values. `ciphertext` shows the last result until the next accept.

## Structure
- Package `aes_pkg` holds:
  - `aes_state_e` enum (IDLE/ROUND/DONE);
  - RCON constant array;
  - `xtime` and `mix_column` functions;
  - `AES_BLOCK_BITS`=128.
- Sub-module `aes_key_step`: combinational KeyStep built from 4 `AES_SBOX` instances.
- The round datapath instantiates `AES_SubBytes` once. ShiftRows is wiring; MixColumns uses the package functions.

## Test plan
- pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f → ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, `out_valid` exactly 10 cycles after accept.
- pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c → 3925841d02dc09fbdc118597196a0b32.
- pt=0, key=0 → 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Hold `out_ready` low 5 cycles in DONE → `ciphertext` and `out_valid` stable. Toggling `in_valid` with a new pt causes no accept. The next block is accepted 1 cycle after the handshake.
- Assert `rst_n` low at round 5, then release and issue the Appendix B vector → all outputs return to reset values; the second result is correct.
- With `AES_ENC_ZEROIZE_EN`: after the output handshake, `ciphertext`==0 in IDLE. Without the macro: it still shows 69c4e0d8….

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, round constants and MixColumns arithmetic for the iterative encrypt core.
package aes_pkg;
   localparam int AES_BLOCK_BITS = 128;

   typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_state_e;

   // Indexed directly by the 4-bit round counter; slots 0 and 11..15 are never used in ROUND.
   localparam logic [7:0] RCON [0:15] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                          8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction
endpackage

// File: rtl/AES_SBOX.sv
// Forward AES S-box as a flat lookup table.
module AES_SBOX (
   input  logic [7:0] a,
   output logic [7:0] y
);
   localparam logic [2047:0] TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   // Entry a sits at bit 2047-8a, which is simply {~a, 3'b111}.
   assign y = TBL[{~a, 3'b111} -: 8];
endmodule

// File: rtl/AES_SubBytes.sv
// SubBytes over a full 128-bit state: sixteen parallel S-boxes.
module AES_SubBytes (
   input  logic [127:0] a,
   output logic [127:0] y
);
   for (genvar i = 0; i < 16; i++) begin : g_sb
      AES_SBOX u_sbox (.a(a[127-8*i -: 8]), .y(y[127-8*i -: 8]));
   end
endmodule

// File: rtl/aes_key_step.sv
// One step of on-the-fly AES-128 key expansion: next round key from current round key and rcon.
module aes_key_step (
   input  logic [127:0] rkey,
   input  logic [7:0]   rcon,
   output logic [127:0] nkey
);
   logic [31:0] w0, w1, w2, w3, rot, sub, temp, n0, n1, n2, n3;

   assign {w0, w1, w2, w3} = rkey;
   assign rot = {w3[23:0], w3[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sw
      AES_SBOX u_sbox (.a(rot[31-8*i -: 8]), .y(sub[31-8*i -: 8]));
   end

   assign temp = sub ^ {rcon, 24'h0};
   assign n0   = w0 ^ temp;
   assign n1   = w1 ^ n0;
   assign n2   = w2 ^ n1;
   assign n3   = w3 ^ n2;
   assign nkey = {n0, n1, n2, n3};
endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption core, one round per clock with on-the-fly key expansion.
// Optional AES_ENC_ZEROIZE_EN clears state and round key once the result is handed off.
module aes_encrypt_iter
   import aes_pkg::*;
#(
   parameter int ROUNDS = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [AES_BLOCK_BITS-1:0] plaintext,
   input  logic [AES_BLOCK_BITS-1:0] key,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [AES_BLOCK_BITS-1:0] ciphertext,
   output logic                      busy
);
   localparam logic [3:0] LAST = 4'(ROUNDS);

   aes_state_e                fsm;
   logic [3:0]                rnd;
   logic [AES_BLOCK_BITS-1:0] st, rkey, nkey, sb, sr, mc, nst;

   AES_SubBytes u_sub (.a(st), .y(sb));
   aes_key_step u_ks  (.rkey(rkey), .rcon(RCON[rnd]), .nkey(nkey));

   // ShiftRows: row r of column c takes row r of column (c+r) mod 4.
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
      end
      assign mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
   end

   assign nst        = ((rnd == LAST) ? sr : mc) ^ nkey;
   assign ciphertext = st;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm       <= IDLE;
         st        <= '0;
         rkey      <= '0;
         rnd       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (fsm)
            IDLE: if (in_valid && in_ready) begin
               st       <= plaintext ^ key;
               rkey     <= key;
               rnd      <= 4'd1;
               fsm      <= ROUND;
               in_ready <= 1'b0;
               busy     <= 1'b1;
            end
            ROUND: begin
               st   <= nst;
               rkey <= nkey;
               if (rnd == LAST) begin
                  fsm       <= DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
               end else begin
                  rnd <= rnd + 4'd1;
               end
            end
            DONE: if (out_valid && out_ready) begin
               fsm       <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
`ifdef AES_ENC_ZEROIZE_EN
               st        <= '0;
               rkey      <= '0;
`else
               st        <= st;
`endif
            end
            default: fsm <= IDLE;
         endcase
      end
   end
endmodule
